// File: rtl/nn_pkg.sv
// Shared types and helpers for the PL_NN layer sequencer: data width, FSM
// state encoding and the ReLU-with-saturation output function.
package nn_pkg;

  localparam int DATA_W = 32;
  // Width at which relu_sat inspects a biased accumulator; must cover ACC_W.
  localparam int SAT_W  = 128;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    BIAS,
    STREAM
  } state_t;

  // Negative -> 0, above 2^31-1 -> 0x7FFF_FFFF, otherwise the low 32 bits.
  function automatic logic [DATA_W-1:0] relu_sat(input logic [SAT_W-1:0] r);
    if (r[SAT_W-1])
      return '0;
    else if (|r[SAT_W-2:DATA_W-1])
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One perceptron lane: signed multiply-accumulate over the pixel/weight
// stream, then bias add and ReLU saturation into a result register.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              clr,
  input  logic              mac_en,
  input  logic              load,
  input  logic [DATA_W-1:0] img,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      prod;
  logic signed [ACC_W-1:0] sum;

  assign prod = 64'($signed(img)) * 64'($signed(w));
  assign sum  = acc + ACC_W'($signed(bias));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (mac_en)
        acc <= acc + ACC_W'(prod);
      if (load)
        result <= relu_sat(SAT_W'(sum));
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer: sweeps the shared BRAM address, drives
// the MAC lanes, then streams one saturated result per perceptron on a_*.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int N_PERC   = 10,
  parameter int ADDR_W   = 10,
  parameter int ACC_W    = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        img_rdata,
  input  logic [DATA_W*N_PERC-1:0] w_rdata,
  input  logic [DATA_W*N_PERC-1:0] bias,
  output logic [DATA_W-1:0]        a_tdata,
  output logic                     a_tvalid,
  input  logic                     a_tready,
  output logic                     a_tlast
);

  localparam int K_W = (N_PERC > 1) ? $clog2(N_PERC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(N_PERC - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic              start_q;
  logic              done_nxt;
  logic              clr;
  logic              load;
  logic              mac_en;
  logic [DATA_W-1:0] result [N_PERC];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      mem_addr <= '0;
      k        <= '0;
      start_q  <= 1'b0;
      done     <= 1'b0;
      mac_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_addr <= addr_nxt;
      k        <= k_nxt;
      start_q  <= start;
      done     <= done_nxt;
      // BRAM data lags the address by one cycle, so the MAC enable does too.
      mac_en   <= mem_en;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    k_nxt     = k;
    done_nxt  = 1'b0;
    clr       = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !start_q) begin
          state_nxt = RUN;
          addr_nxt  = '0;
          k_nxt     = '0;
          clr       = 1'b1;
        end
      end
      RUN: begin
        if (mem_addr == LAST_ADDR) begin
          state_nxt = DRAIN;
          addr_nxt  = '0;
        end else begin
          addr_nxt = mem_addr + 1'b1;
        end
      end
      DRAIN: state_nxt = BIAS;
      BIAS: begin
        load      = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (a_tready) begin
          if (k == LAST_K) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            done_nxt  = 1'b1;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_en   = (state == RUN);
  assign a_tvalid = (state == STREAM);
  assign a_tlast  = a_tvalid && (k == LAST_K);
  assign a_tdata  = a_tvalid ? result[k] : '0;

  for (genvar n = 0; n < N_PERC; n++) begin : g_lane
    nn_mac_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .clr     (clr),
      .mac_en  (mac_en),
      .load    (load),
      .img     (img_rdata),
      .w       (w_rdata[DATA_W*n +: DATA_W]),
      .bias    (bias[DATA_W*n +: DATA_W]),
      .result  (result[n])
    );
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: directed and randomized layer
// runs compared against a plain-arithmetic dot-product/ReLU reference model.
module tb_nn_layer_sequencer;

  localparam int N  = 5;
  localparam int P  = 3;
  localparam int AW = 3;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   img_rdata = '0;
  logic [32*P-1:0] w_rdata = '0;
  logic [32*P-1:0] bias;
  logic [31:0]   a_tdata;
  logic          a_tvalid;
  logic          a_tready = 1'b1;
  logic          a_tlast;

  int          img_m [8];
  int          w_m   [P][8];
  int          bias_m[P];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  nn_layer_sequencer #(
    .N_INPUTS (N),
    .N_PERC   (P),
    .ADDR_W   (AW),
    .ACC_W    (64)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .img_rdata (img_rdata),
    .w_rdata   (w_rdata),
    .bias      (bias),
    .a_tdata   (a_tdata),
    .a_tvalid  (a_tvalid),
    .a_tready  (a_tready),
    .a_tlast   (a_tlast)
  );

  always #5 ACLK = ~ACLK;

  // Registered-read BRAM models shared by the image and all weight memories.
  always @(posedge ACLK) begin
    if (mem_en) begin
      img_rdata <= img_m[mem_addr];
      for (int l = 0; l < P; l++) w_rdata[32*l +: 32] <= w_m[l][mem_addr];
    end
  end

  always_comb begin
    bias = '0;
    for (int l = 0; l < P; l++) bias[32*l +: 32] = bias_m[l];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product in 64-bit wrapping arithmetic, bias, ReLU, clamp.
  task automatic build_expected();
    longint acc;
    exp_q.delete();
    for (int l = 0; l < P; l++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(img_m[i]) * longint'(w_m[l][i]);
      acc += longint'(bias_m[l]);
      if (acc < 0)                exp_q.push_back(32'd0);
      else if (acc > 2147483647)  exp_q.push_back(32'h7FFF_FFFF);
      else                        exp_q.push_back(acc[31:0]);
    end
  endtask

  task automatic set_ramp(input int b0, input int b1, input int b2);
    for (int i = 0; i < N; i++) begin
      img_m[i] = 4 * i;
      for (int l = 0; l < P; l++) w_m[l][i] = 4 * i;
    end
    bias_m[0] = b0; bias_m[1] = b1; bias_m[2] = b2;
  endtask

  task automatic set_const(input int px, input int wt);
    for (int i = 0; i < N; i++) begin
      img_m[i] = px;
      for (int l = 0; l < P; l++) w_m[l][i] = wt;
    end
    for (int l = 0; l < P; l++) bias_m[l] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_mem_en"},   mem_en,   0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_tvalid"},   a_tvalid, 0);
    check({tag, "_tlast"},    a_tlast,  0);
    check({tag, "_tdata"},    a_tdata,  0);
  endtask

  // One layer run from a fresh start edge. Cycle numbers are relative to the
  // edge E that samples start; the task returns at the negedge of the done cycle.
  // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random.
  task automatic do_run(input int ready_mode, input int hold, input int repulse_at);
    int          cyc, beat, s, first_valid;
    bit          got_done, prev_stall, prev_last;
    logic [31:0] prev_data;
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};
    build_expected();
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK); #1;
    cyc = 1; beat = 0; s = 0; first_valid = 0;
    got_done = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    while (!got_done && cyc < 200) begin
      if (cyc == hold) start = 1'b0;
      if (cyc == repulse_at) start = 1'b1;
      if (cyc == repulse_at + 1) start = 1'b0;
      case (ready_mode)
        0:       a_tready = 1'b1;
        1:       a_tready = a_tvalid ? pat[s % 6] : 1'b0;
        default: a_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge ACLK);
      check("mem_en", mem_en, (cyc <= N));
      if (cyc <= N) check("mem_addr", mem_addr, cyc - 1);
      if (prev_stall) begin
        check("stall_tvalid", a_tvalid, 1);
        check("stall_tdata",  a_tdata,  prev_data);
        check("stall_tlast",  a_tlast,  prev_last);
      end
      if (a_tvalid) begin
        if (first_valid == 0) begin
          first_valid = cyc;
          check("first_valid_cycle", cyc, N + 3);
        end
        s++;
        if (a_tready) begin
          if (beat < P) begin
            check("beat_tdata", a_tdata, exp_q[beat]);
            check("beat_tlast", a_tlast, (beat == P - 1));
          end else begin
            check("extra_beat", beat, P - 1);
          end
          beat++;
        end
      end
      prev_stall = a_tvalid && !a_tready;
      prev_data  = a_tdata;
      prev_last  = a_tlast;
      if (done) begin
        got_done = 1;
        check("busy_at_done", busy, 0);
        check("beat_count", beat, P);
        if (ready_mode == 0) check("done_cycle", cyc, N + P + 3);
      end else begin
        check("busy_in_run", busy, 1);
        @(posedge ACLK); #1;
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  // Idle period after a run: start is dropped after n_hi cycles; nothing may
  // restart and done must not repeat.
  task automatic idle_watch(input int n, input int n_hi);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #1;
      if (i == n_hi) start = 1'b0;
      @(negedge ACLK);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      img_m[i] = 0;
      for (int l = 0; l < P; l++) w_m[l][i] = 0;
    end
    for (int l = 0; l < P; l++) bias_m[l] = 0;

    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_reset_outputs("post_reset");

    // Smoke: ramp data, zero biases.
    set_ramp(0, 0, 0);
    do_run(0, 1, 0);
    idle_watch(2, 0);

    // Bias add and ReLU clamp to zero.
    set_ramp(20, -1000, -480);
    do_run(0, 1, 0);
    idle_watch(2, 0);

    // Backpressure pattern.
    set_ramp(0, 0, 0);
    do_run(1, 1, 0);
    idle_watch(2, 0);

    // Start held across done, then a mid-run pulse: neither may retrigger.
    do_run(0, 20, 0);
    idle_watch(12, 9);
    do_run(0, 1, 4);
    idle_watch(4, 0);

    // Positive and negative overflow.
    set_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_run(0, 1, 0);
    idle_watch(1, 0);
    set_const(32'h7FFF_FFFF, 32'h8000_0001);
    do_run(0, 1, 0);
    idle_watch(1, 0);

    // Randomized data, biases and backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        img_m[i] = int'($urandom_range(0, 8191)) - 4096;
        for (int l = 0; l < P; l++) w_m[l][i] = int'($urandom_range(0, 8191)) - 4096;
      end
      for (int l = 0; l < P; l++) bias_m[l] = int'($urandom_range(0, 2000000)) - 1000000;
      do_run(2, 1, 0);
      idle_watch(1, 0);
    end

    // Reset asserted during RUN while address 2 is driven.
    set_ramp(0, 0, 0);
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    check("pre_reset_addr", mem_addr, 2);
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_reset_outputs("after_release");
    do_run(0, 1, 0);
    idle_watch(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
